// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick divider: one-cycle pulse every DIV clocks, restarted by clr.
module uart_rx_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1)) && !clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver, 8 data bits, LSB first, one stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err port.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam logic [3:0] MID_TICK = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] BIT_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t     state, state_n;
    logic       rx_s1, rx_s2, rx_prev;
    logic [2:0] fill;
    logic [3:0] tcnt, tcnt_n;
    logic [2:0] bcnt, bcnt_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] data_n;
    logic       valid_n, ferr_n;
    logic       tick, fall, bit_end, parity_bad;
`ifdef UART_RX_PARITY_EN
    logic       par_q, par_n, perr_n;
`endif

    // fill qualifies the edge detector until rx_prev holds a real line sample,
    // so a line held low from reset never looks like a start edge.
    assign fall = fill[2] && rx_prev && !rx_s2;
    assign busy = (state != IDLE);

    uart_rx_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .tick (tick)
    );

`ifdef UART_RX_PARITY_EN
    assign parity_bad = ^{shreg, par_q};
`else
    assign parity_bad = 1'b0;
`endif

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        data_n  = data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        bit_end = tick && (tcnt == BIT_TICK);
`ifdef UART_RX_PARITY_EN
        par_n   = par_q;
        perr_n  = 1'b0;
`endif
        if (tick && !bit_end)
            tcnt_n = tcnt + 1'b1;
        case (state)
            IDLE: begin
                tcnt_n = '0;
                bcnt_n = '0;
                if (fall)
                    state_n = START;
            end
            START: begin
                if (tick && tcnt == MID_TICK) begin
                    tcnt_n  = '0;
                    state_n = rx_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    tcnt_n  = '0;
                    shreg_n = {rx_s2, shreg[7:1]};
                    bcnt_n  = bcnt + 1'b1;
                    if (bcnt == LAST_BIT)
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tcnt_n  = '0;
                    par_n   = rx_s2;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tcnt_n  = '0;
                    state_n = IDLE;
                    ferr_n  = !rx_s2;
                    if (rx_s2 && !parity_bad) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    perr_n = parity_bad;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            fill      <= '0;
            tcnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            rx_s1     <= rx;
            rx_s2     <= rx_s1;
            rx_prev   <= rx_s2;
            fill      <= {fill[1:0], 1'b1};
            tcnt      <= tcnt_n;
            bcnt      <= bcnt_n;
            shreg     <= shreg_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_n;
            parity_err <= perr_n;
`endif
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate in Bd.
REQ-003 clk  input  1  system clock; one clock domain, all state on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserts immediately, releases on the next clk rising edge.
REQ-005 rx  input  1  asynchronous serial line, idle high.
REQ-006 data  output  8  last received byte, LSB first on the line.
REQ-007 valid  output  1  one-cycle pulse; data holds a good byte.
REQ-008 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 parity_err  output  1  one-cycle pulse on parity mismatch; exists only with UART_RX_PARITY_EN.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer reset to 1; all logic uses the synchronized value.
REQ-012 An oversample tick SHALL pulse for one clk every DIV = CLK_FREQ/(BAUD*16) cycles, integer-truncated (651 at defaults).
REQ-013 The tick counter SHALL restart from 0 when START is entered, so ticks align to the detected start edge.
REQ-014 States SHALL be IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-015 IDLE->START SHALL occur on a synchronized high-to-low transition of rx; a low level held from reset SHALL NOT start a frame.
REQ-016 START SHALL sample rx on the 8th tick; low->DATA, high->IDLE (glitch rejected, no output pulse).
REQ-017 DATA SHALL sample every 16th tick after the start sample and shift each bit into bit 7 of a shift register, 8 bits total.
REQ-018 STOP SHALL sample rx 16 ticks after the last data (or parity) sample.
REQ-019 A high stop sample SHALL load data from the shift register and pulse valid one clk later.
REQ-020 A low stop sample SHALL pulse frame_err and leave data and valid unchanged.
REQ-021 The block SHALL return to IDLE in the clk after the stop sample; a new frame needs a fresh falling edge (break conditions produce a single frame_err).
REQ-022 Total latency from the start edge to valid SHALL be 2 sync cycles plus 9.5 bit periods, within ±1 tick.
REQ-023 data SHALL hold its value until the next good byte, with no consumer handshake; an unread byte is overwritten.

Reset
REQ-024 While rst is low: state=IDLE, data=0x00, valid=0, frame_err=0, parity_err=0, busy=0, counters=0, synchronizer=1.
REQ-025 Reset asserted mid-frame SHALL discard the partial byte without any pulse.

Configuration
REQ-026 With UART_RX_PARITY_EN defined: PARITY samples one even-parity bit after DATA; a mismatch pulses parity_err together with the stop outcome, and valid is suppressed.
REQ-027 Without UART_RX_PARITY_EN: no PARITY state and no parity_err port; the frame is 8N1.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum, DATA_BITS=8 and OVERSAMPLE=16.
REQ-029 The tick divider SHALL be the sub-module uart_rx_tick (ports clk, rst, clr, tick).

Verification
REQ-030 8N1 frame 0xA5 at 9600 Bd -> exactly one valid, data=0xA5, no frame_err, busy low afterwards.
REQ-031 Back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses, data 0x00 then 0xFF.
REQ-032 Low glitch lasting 4 ticks on an idle line -> no valid, no frame_err, back in IDLE after the 8th tick.
REQ-033 Frame 0x3C with stop bit forced low -> one frame_err, no valid, data keeps its previous value.
REQ-034 rst low at bit 4 of 0x5A, then a full 0x81 -> no pulse for 0x5A; valid with data=0x81.
REQ-035 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 (expected 1) -> parity_err pulse, no valid.
